// File: rtl/pcihellocore_leds_out_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
// There is no waitrequest, and read data comes back one cycle after the address.
`timescale 1ns/1ps
interface pcihellocore_leds_out_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pcihellocore_leds_out.sv
// LED output PIO with atomic set/clear aliases and a prescaled per-bit blink mask.
// Registers: 0 DATA, 1 BLINK_MASK, 2 OUTSET (write) / out_port (read), 3 OUTCLEAR.
`timescale 1ns/1ps
module pcihellocore_leds_out #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               BLINK_DIV   = 25000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pcihellocore_leds_out_if.slave avs,
    output logic [WIDTH-1:0]       out_port
);
    localparam int               CNT_W    = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [WIDTH-1:0] data_reg, data_next;
    logic [WIDTH-1:0] mask_reg, mask_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             phase_reg, phase_next;
    logic [31:0]      rd_reg;
    logic [WIDTH-1:0] rd_sel;
    logic [WIDTH-1:0] wd;
    logic             wr_en;
    logic             wrap;
    logic             unused_bits;

    assign wr_en       = avs.chipselect & ~avs.write_n;
    assign wd          = avs.writedata[WIDTH-1:0];
    assign wrap        = (cnt_reg == CNT_LAST);
    assign unused_bits = ^avs.writedata;

    always_comb begin
        data_next  = data_reg;
        mask_next  = mask_reg;
        cnt_next   = wrap ? '0 : cnt_reg + CNT_W'(1);
        phase_next = phase_reg ^ wrap;
        if (wr_en) begin
            case (avs.address)
                2'd0: data_next = wd;
                2'd1: begin
                    // Restart the prescaler so new blink bits show DATA for a full half-period.
                    mask_next  = wd;
                    cnt_next   = '0;
                    phase_next = 1'b0;
                end
                2'd2: data_next = data_reg | wd;
                2'd3: data_next = data_reg & ~wd;
                default: data_next = data_reg;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_blink
            assign out_next[gi] = data_reg[gi] ^ (mask_reg[gi] & phase_reg);
        end
    endgenerate

    always_comb begin
        rd_sel = '0;
        case (avs.address)
            2'd0:    rd_sel = data_reg;
            2'd1:    rd_sel = mask_reg;
            2'd2:    rd_sel = out_reg;
            default: rd_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg  <= RESET_VALUE;
            mask_reg  <= '0;
            out_reg   <= RESET_VALUE;
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
            rd_reg    <= '0;
        end else begin
            data_reg  <= data_next;
            mask_reg  <= mask_next;
            out_reg   <= out_next;
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
            rd_reg    <= 32'(rd_sel);
        end
    end

    assign avs.readdata = rd_reg;
    assign out_port     = out_reg;
endmodule

// File: tb/tb_pcihellocore_leds_out.sv
// Self-checking bench for the LED output PIO; a cycle-indexed reference model
// derives blink phase arithmetically from the edge count since the last prescaler clear.
`timescale 1ns/1ps
module tb_pcihellocore_leds_out;
    localparam int         WIDTH = 8;
    localparam logic [7:0] RV    = 8'hA5;
    localparam int         DIV   = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] out_port;

    pcihellocore_leds_out_if bus ();

    pcihellocore_leds_out #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(RV),
        .BLINK_DIV  (DIV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avs     (bus),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: state after edge number edge_n; epoch is the edge after which the count was 0.
    logic [7:0]  m_data = RV;
    logic [7:0]  m_mask = 8'h00;
    logic [7:0]  m_out  = RV;
    logic [31:0] m_rd   = 32'h0;
    logic [7:0]  m_wd;
    logic        m_ph;
    int unsigned edge_n = 0;
    int unsigned epoch  = 0;

    function automatic logic phase_after(input int unsigned n, input int unsigned ep);
        return (((n - ep) / DIV) % 2) == 1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data = RV;
            m_mask = 8'h00;
            m_out  = RV;
            m_rd   = 32'h0;
            epoch  = edge_n;
        end else begin
            m_ph = phase_after(edge_n, epoch);
            case (bus.address)
                2'd0:    m_rd = {24'h0, m_data};
                2'd1:    m_rd = {24'h0, m_mask};
                2'd2:    m_rd = {24'h0, m_out};
                default: m_rd = 32'h0;
            endcase
            m_out  = m_data ^ (m_mask & {8{m_ph}});
            edge_n = edge_n + 1;
            if (bus.chipselect && !bus.write_n) begin
                m_wd = bus.writedata[7:0];
                case (bus.address)
                    2'd0: m_data = m_wd;
                    2'd1: begin m_mask = m_wd; epoch = edge_n; end
                    2'd2: m_data = m_data | m_wd;
                    default: m_data = m_data & ~m_wd;
                endcase
            end
        end
    end

    // Called at a falling edge; the write is sampled at the next rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic cs);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = cs;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        $display("wr addr=%0d data=%08h cs=%0b out=%02h", a, d, cs, out_port);
    endtask

    task automatic test_reset();
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_port !== RV) begin errors++; $display("FAIL reset_out: got %02h expected %02h", out_port, RV); end
        checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_rd: got %08h expected %08h", bus.readdata, 32'h0); end
        reset_n = 1'b1;
        @(negedge clk);
        bus_write(2'd0, 32'h12, 1'b1);
        bus.address = 2'd0;
        @(negedge clk);
        checks++; if (bus.readdata !== 32'h12) begin errors++; $display("FAIL pre_reset_rd: got %08h expected %08h", bus.readdata, 32'h12); end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_port !== RV) begin errors++; $display("FAIL async_reset_out: got %02h expected %02h", out_port, RV); end
        checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL async_reset_rd: got %08h expected %08h", bus.readdata, 32'h0); end
        @(negedge clk);
        reset_n = 1'b1;
        bus.address = 2'd0;
        @(negedge clk);
        checks++; if (bus.readdata !== 32'h000000A5) begin errors++; $display("FAIL post_reset_rd: got %08h expected %08h", bus.readdata, 32'h000000A5); end
        $display("txn reset done out=%02h rd=%08h", out_port, bus.readdata);
    endtask

    task automatic test_data_write();
        bus_write(2'd0, 32'h3C, 1'b1);
        checks++; if (out_port !== RV) begin errors++; $display("FAIL data_latency_early: got %02h expected %02h", out_port, RV); end
        @(negedge clk);
        checks++; if (out_port !== 8'h3C) begin errors++; $display("FAIL data_out: got %02h expected %02h", out_port, 8'h3C); end
        checks++; if (bus.readdata !== 32'h3C) begin errors++; $display("FAIL data_rd: got %08h expected %08h", bus.readdata, 32'h3C); end
        bus_write(2'd0, 32'hFFFFFF0F, 1'b1);
        @(negedge clk);
        checks++; if (bus.readdata !== 32'h0000000F) begin errors++; $display("FAIL data_upper_rd: got %08h expected %08h", bus.readdata, 32'h0F); end
        checks++; if (out_port !== 8'h0F) begin errors++; $display("FAIL data_upper_out: got %02h expected %02h", out_port, 8'h0F); end
    endtask

    task automatic test_set_clear();
        logic [1:0]  ta [7] = '{2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd2};
        logic [31:0] td [7] = '{32'h3C, 32'h81, 32'h0C, 32'h00, 32'h00, 32'hFF, 32'hFFFFFF00};
        logic        tc [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0]  te [7] = '{8'h3C, 8'hBD, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1};
        for (int i = 0; i < 7; i++) begin
            bus_write(ta[i], td[i], tc[i]);
            bus.address = 2'd0;
            @(negedge clk);
            checks++; if (bus.readdata !== {24'h0, te[i]}) begin errors++; $display("FAIL set_clear_rd[%0d]: got %08h expected %08h", i, bus.readdata, {24'h0, te[i]}); end
            checks++; if (out_port !== te[i]) begin errors++; $display("FAIL set_clear_out[%0d]: got %02h expected %02h", i, out_port, te[i]); end
        end
    endtask

    task automatic test_blink();
        logic [7:0] prev;
        logic [7:0] exp;
        bus_write(2'd0, 32'h00, 1'b1);
        bus_write(2'd1, 32'h03, 1'b1);
        bus.address = 2'd2;
        prev = out_port;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = (k >= 5 && k <= 8) ? 8'h03 : 8'h00;
            checks++; if (out_port !== exp) begin errors++; $display("FAIL blink_out[%0d]: got %02h expected %02h", k, out_port, exp); end
            checks++; if (bus.readdata !== {24'h0, prev}) begin errors++; $display("FAIL blink_rd2[%0d]: got %08h expected %08h", k, bus.readdata, {24'h0, prev}); end
            $display("txn blink k=%0d out=%02h rd=%08h", k, out_port, bus.readdata);
            prev = out_port;
        end
        bus.address = 2'd1;
        @(negedge clk);
        checks++; if (bus.readdata !== 32'h03) begin errors++; $display("FAIL blink_mask_rd: got %08h expected %08h", bus.readdata, 32'h03); end
    endtask

    task automatic test_wrap_write();
        logic       found;
        logic [7:0] exp;
        bus_write(2'd0, 32'h50, 1'b1);
        bus_write(2'd1, 32'h0F, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) begin
            if (((edge_n - epoch) % DIV) == DIV - 1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL wrap_wait: got timeout expected wrap cycle"); end
        bus_write(2'd1, 32'hF0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp = (k <= 4) ? 8'h50 : 8'hA0;
            checks++; if (out_port !== exp) begin errors++; $display("FAIL wrap_out[%0d]: got %02h expected %02h", k, out_port, exp); end
        end
        found = 1'b0;
        for (int i = 0; i < 2 * DIV + 2; i++) begin
            if (phase_after(edge_n, epoch)) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL phase_wait: got timeout expected phase 1"); end
        @(negedge clk);
        bus_write(2'd1, 32'h00, 1'b1);
        checks++; if (out_port !== 8'hA0) begin errors++; $display("FAIL stop_before: got %02h expected %02h", out_port, 8'hA0); end
        @(negedge clk);
        checks++; if (out_port !== 8'h50) begin errors++; $display("FAIL stop_out: got %02h expected %02h", out_port, 8'h50); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] prev;
        bus_write(2'd3, 32'hFFFFFFFF, 1'b1);
        bus_write(2'd2, 32'h5A, 1'b1);
        bus.address = 2'd3;
        @(negedge clk);
        checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL addr3_rd: got %08h expected %08h", bus.readdata, 32'h0); end
        bus_write(2'd1, 32'h81, 1'b1);
        bus.address = 2'd0;
        @(negedge clk);
        checks++; if (bus.readdata !== 32'h5A) begin errors++; $display("FAIL b2b_addr0: got %08h expected %08h", bus.readdata, 32'h5A); end
        bus.address = 2'd1;
        prev = out_port;
        @(negedge clk);
        checks++; if (bus.readdata !== 32'h81) begin errors++; $display("FAIL b2b_addr1: got %08h expected %08h", bus.readdata, 32'h81); end
        bus.address = 2'd2;
        prev = out_port;
        @(negedge clk);
        checks++; if (bus.readdata !== {24'h0, prev}) begin errors++; $display("FAIL b2b_addr2: got %08h expected %08h", bus.readdata, {24'h0, prev}); end
        for (int i = 0; i < 60; i++) begin
            bus.address    = 2'($urandom);
            bus.chipselect = 1'($urandom);
            bus.write_n    = 1'($urandom);
            bus.writedata  = $urandom;
            @(negedge clk);
            $display("txn rnd i=%0d addr=%0d cs=%0b wn=%0b wd=%08h out=%02h rd=%08h",
                     i, bus.address, bus.chipselect, bus.write_n, bus.writedata, out_port, bus.readdata);
            checks++; if (out_port !== m_out) begin errors++; $display("FAIL rnd_out[%0d]: got %02h expected %02h", i, out_port, m_out); end
            checks++; if (bus.readdata !== m_rd) begin errors++; $display("FAIL rnd_rd[%0d]: got %08h expected %08h", i, bus.readdata, m_rd); end
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_set_clear();
        test_blink();
        test_wrap_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
